// File: rtl/mvb_pkg.sv
// Shared types, constants and helpers for the MVB receive sequencer.
package mvb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA     = 2'd1,
        CRC      = 2'd2,
        END_WAIT = 2'd3
    } state_t;

    localparam logic [1:0] ERR_BAD_SIZE    = 2'b00;
    localparam logic [1:0] ERR_END_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_SYNC_LOST   = 2'b10;
    localparam logic [1:0] ERR_RESTART     = 2'b11;

    localparam int CHK_BITS    = 8;
    localparam int WORD_BITS   = 16;
    localparam int GROUP_WORDS = 4;

    // Zero marks an unsupported size code.
    function automatic logic [4:0] size_to_words(input logic is_slave, input logic [2:0] code);
        logic [4:0] n;
        n = 5'd0;
        if (!is_slave) begin
            n = 5'd1;
        end else begin
            case (code)
                3'd0:    n = 5'd1;
                3'd1:    n = 5'd2;
                3'd2:    n = 5'd4;
                3'd3:    n = 5'd8;
                3'd4:    n = 5'd16;
                default: n = 5'd0;
            endcase
        end
        return n;
    endfunction

    function automatic logic [2:0] group_len(input logic [4:0] n);
        return (n > 5'(GROUP_WORDS)) ? 3'(GROUP_WORDS) : n[2:0];
    endfunction

endpackage

// File: rtl/mvb_rx_sequencer_if.sv
// Bus between delimiter detectors/deserializer/frame buffer and the receive sequencer.
// crc_byte/crc_valid exist only when MVB_RX_CRC_CAPTURE_EN is defined.
interface mvb_rx_sequencer_if #(
    parameter int ADDR_W = 4
);
    // word_valid is a one-cycle pulse with no back-pressure; the only flow control is
    // des_wait, which holds and clears the deserializer whenever it is 1. wr_en is a
    // single-cycle write strobe the buffer must always accept.
    logic              start_det;
    logic              frame_is_slave;
    logic [2:0]        size_code;
    logic              word_valid;
    logic [15:0]       word_in;
    logic              bit_in;
    logic              end_det;
    logic              des_wait;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              crc_window;
    logic              busy;
    logic              frame_done;
    logic              frame_err;
    logic [1:0]        err_code;
    mvb_pkg::state_t   state;
`ifdef MVB_RX_CRC_CAPTURE_EN
    logic [7:0]        crc_byte;
    logic              crc_valid;
`endif

    modport master (
        output start_det, frame_is_slave, size_code, word_valid, word_in, bit_in, end_det,
`ifdef MVB_RX_CRC_CAPTURE_EN
        input  crc_byte, crc_valid,
`endif
        input  des_wait, wr_en, wr_addr, wr_data, crc_window, busy,
        input  frame_done, frame_err, err_code, state
    );

    modport slave (
        input  start_det, frame_is_slave, size_code, word_valid, word_in, bit_in, end_det,
`ifdef MVB_RX_CRC_CAPTURE_EN
        output crc_byte, crc_valid,
`endif
        output des_wait, wr_en, wr_addr, wr_data, crc_window, busy,
        output frame_done, frame_err, err_code, state
    );

endinterface

// File: rtl/mvb_rx_crc_capture.sv
// Captures the 8 check-sequence bits MSB-first; used only when MVB_RX_CRC_CAPTURE_EN is defined.
module mvb_rx_crc_capture
    import mvb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                window,
    input  logic                bit_in,
    output logic [CHK_BITS-1:0] crc_byte,
    output logic                crc_valid
);

    logic [2:0] bit_cnt;

    // crc_byte is the shift register itself, so it holds until the next window shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_byte  <= '0;
            crc_valid <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            crc_valid <= window && (bit_cnt == 3'(CHK_BITS - 1));
            if (window) begin
                crc_byte <= {crc_byte[CHK_BITS-2:0], bit_in};
                bit_cnt  <= bit_cnt + 3'd1;
            end else begin
                bit_cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/mvb_rx_sequencer.sv
// MVB frame receive controller: gates the deserializer, writes words, inserts check gaps.
// Optional check-byte capture is enabled by defining MVB_RX_CRC_CAPTURE_EN.
module mvb_rx_sequencer
    import mvb_pkg::*;
#(
    parameter int END_TIMEOUT = 12,
    parameter int MAX_WORDS   = 16
) (
    input  logic              clk_3M,
    input  logic              rst,
    mvb_rx_sequencer_if.slave bus
);

    localparam int               ADDR_W   = $clog2(MAX_WORDS);
    localparam int               TMO_W    = $clog2(END_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(END_TIMEOUT - 1);
    localparam logic [5:0]       MAX_N    = 6'(MAX_WORDS);

    state_t           state, state_nxt;
    logic [3:0]       bit_cnt, bit_cnt_nxt;
    logic [1:0]       grp_cnt, grp_cnt_nxt;
    logic [4:0]       word_cnt, word_cnt_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             word_due, word_due_nxt;
    logic [4:0]       frame_words, frame_words_nxt;
    logic [2:0]       group_words, group_words_nxt;
    logic             done_q, done_nxt;
    logic             err_q, err_nxt;
    logic [1:0]       code_q, code_nxt;
    logic             wr_en;
    logic [4:0]       start_words;
    logic             start_bad;
    logic             grp_full;

    always_ff @(posedge clk_3M or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            grp_cnt     <= '0;
            word_cnt    <= '0;
            tmo_cnt     <= '0;
            word_due    <= 1'b0;
            frame_words <= '0;
            group_words <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= 2'b00;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            grp_cnt     <= grp_cnt_nxt;
            word_cnt    <= word_cnt_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            word_due    <= word_due_nxt;
            frame_words <= frame_words_nxt;
            group_words <= group_words_nxt;
            done_q      <= done_nxt;
            err_q       <= err_nxt;
            code_q      <= code_nxt;
        end
    end

    // word_due marks the cycle after a 16-bit word completes; the deserializer's
    // word_valid must land there, even when that cycle is already the first CRC bit.
    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        grp_cnt_nxt     = grp_cnt;
        word_cnt_nxt    = word_cnt;
        tmo_cnt_nxt     = tmo_cnt;
        word_due_nxt    = 1'b0;
        frame_words_nxt = frame_words;
        group_words_nxt = group_words;
        done_nxt        = 1'b0;
        err_nxt         = 1'b0;
        code_nxt        = code_q;
        wr_en           = 1'b0;
        grp_full        = 1'b0;
        start_words     = size_to_words(bus.frame_is_slave, bus.size_code);
        start_bad       = (start_words == 5'd0) || ({1'b0, start_words} > MAX_N);

        if (state == IDLE) begin
            if (bus.start_det) begin
                if (start_bad) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_BAD_SIZE;
                end else begin
                    state_nxt       = DATA;
                    bit_cnt_nxt     = '0;
                    grp_cnt_nxt     = '0;
                    word_cnt_nxt    = '0;
                    frame_words_nxt = start_words;
                    group_words_nxt = group_len(start_words);
                    code_nxt        = 2'b00;
                end
            end
        end else if (bus.start_det) begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_RESTART;
            state_nxt = IDLE;
        end else if (word_due && !bus.word_valid) begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_SYNC_LOST;
            state_nxt = IDLE;
        end else begin
            if (word_due) begin
                wr_en        = 1'b1;
                word_cnt_nxt = word_cnt + 5'd1;
                grp_cnt_nxt  = grp_cnt + 2'd1;
            end
            case (state)
                DATA: begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'(WORD_BITS - 1)) begin
                        word_due_nxt = 1'b1;
                        // Count the word about to be written when deciding on the gap.
                        grp_full = (({1'b0, grp_cnt} + 3'd1) >= group_words) ||
                                   ((word_cnt + 5'd1) >= frame_words);
                        if (grp_full) begin
                            state_nxt = CRC;
                        end
                    end
                end
                CRC: begin
                    if (bit_cnt == 4'(CHK_BITS - 1)) begin
                        bit_cnt_nxt = '0;
                        if (word_cnt_nxt < frame_words) begin
                            state_nxt   = DATA;
                            grp_cnt_nxt = '0;
                        end else begin
                            state_nxt   = END_WAIT;
                            tmo_cnt_nxt = '0;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end
                END_WAIT: begin
                    if (bus.end_det) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_END_TIMEOUT;
                        state_nxt = IDLE;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.des_wait   = (state != DATA);
    assign bus.crc_window = (state == CRC);
    assign bus.busy       = (state != IDLE);
    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = wr_en ? word_cnt[ADDR_W-1:0] : '0;
    assign bus.wr_data    = wr_en ? bus.word_in : '0;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.err_code   = code_q;
    assign bus.state      = state;

`ifdef MVB_RX_CRC_CAPTURE_EN
    mvb_rx_crc_capture u_crc_capture (
        .clk       (clk_3M),
        .rst       (rst),
        .window    (state == CRC),
        .bit_in    (bus.bit_in),
        .crc_byte  (bus.crc_byte),
        .crc_valid (bus.crc_valid)
    );
`else
    logic unused_bit_in;
    assign unused_bit_in = bus.bit_in;
`endif

endmodule

// File: tb/tb_mvb_rx_sequencer.sv
// Directed self-checking bench for mvb_rx_sequencer (default build; capture checks under MVB_RX_CRC_CAPTURE_EN).
module tb_mvb_rx_sequencer;
    import mvb_pkg::*;

    logic clk_3M = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] exp_q[$];
    logic [3:0]  obs_addr[$];
    logic [15:0] obs_data[$];
    int          crc_hi, crc_bad, data_bad, stray;
    logic [15:0] word_base;
    logic [7:0]  crc_pat;

    always #5 clk_3M = ~clk_3M;

    mvb_rx_sequencer_if #(.ADDR_W(4)) bus ();

    mvb_rx_sequencer #(.END_TIMEOUT(12), .MAX_WORDS(16)) dut (
        .clk_3M (clk_3M),
        .rst    (rst),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk_3M);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_3M);
    endtask

    task automatic idle_inputs();
        bus.start_det  = 1'b0;
        bus.end_det    = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_in    = 16'h0000;
        bus.bit_in     = 1'b0;
    endtask

    task automatic record_write();
        if (bus.wr_en === 1'b1) begin
            obs_addr.push_back(bus.wr_addr);
            obs_data.push_back(bus.wr_data);
        end
        if (bus.frame_err !== 1'b0 || bus.frame_done !== 1'b0) stray++;
    endtask

    task automatic start_frame(input logic slave, input logic [2:0] code);
        exp_q.delete();
        obs_addr.delete();
        obs_data.delete();
        crc_hi = 0; crc_bad = 0; data_bad = 0; stray = 0;
        tick();
        idle_inputs();
        bus.start_det      = 1'b1;
        bus.frame_is_slave = slave;
        bus.size_code      = code;
    endtask

    // Line-timed deserializer: word_valid lands the cycle after each word's 16th bit.
    task automatic drive_frame(input int n, input int g);
        logic        pend;
        logic [15:0] pend_data;
        int          widx;
        pend = 1'b0; pend_data = 16'h0; widx = 0;
        for (int grp = 0; grp < n / g; grp++) begin
            for (int w = 0; w < g; w++) begin
                for (int b = 0; b < 16; b++) begin
                    tick();
                    idle_inputs();
                    bus.word_valid = pend;
                    bus.word_in    = pend ? pend_data : 16'h0;
                    pend = 1'b0;
                    settle();
                    if (bus.des_wait !== 1'b0 || bus.crc_window !== 1'b0) data_bad++;
                    record_write();
                    if (b == 15) begin
                        pend      = 1'b1;
                        pend_data = word_base + 16'(widx) * 16'h0101;
                        exp_q.push_back(pend_data);
                        widx++;
                    end
                end
            end
            for (int k = 0; k < 8; k++) begin
                tick();
                idle_inputs();
                bus.word_valid = pend;
                bus.word_in    = pend ? pend_data : 16'h0;
                bus.bit_in     = crc_pat[3'(7 - k)];
                pend = 1'b0;
                settle();
                if (bus.crc_window === 1'b1 && bus.des_wait === 1'b1) crc_hi++;
                else crc_bad++;
                record_write();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.frame_is_slave = 1'b0;
        bus.size_code      = 3'd0;
        crc_pat   = 8'h00;
        word_base = 16'h0;
        repeat (3) settle();
        checks++;
        if (bus.des_wait !== 1'b1) begin
            failures++; $display("FAIL reset_des_wait: got %b, required 1", bus.des_wait);
        end
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.crc_window, bus.busy,
             bus.frame_done, bus.frame_err, bus.err_code} !== 27'h0) begin
            failures++;
            $display("FAIL reset_outputs: wr_en=%b addr=%h data=%h crc=%b busy=%b done=%b err=%b code=%b, required all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.crc_window, bus.busy,
                     bus.frame_done, bus.frame_err, bus.err_code);
        end
        rst = 1'b0;
        tick();
        settle();
        checks++;
        if (bus.busy !== 1'b0 || bus.des_wait !== 1'b1) begin
            failures++; $display("FAIL reset_release: busy=%b des_wait=%b, required 0/1", bus.busy, bus.des_wait);
        end
    endtask

    task automatic test_master_frame();
        logic [15:0] exp_w;
        word_base = 16'hA5C3;
        crc_pat   = 8'h3B;
        start_frame(1'b0, 3'd0);
        drive_frame(1, 1);
        checks++;
        if (obs_data.size() != 1) begin
            failures++; $display("FAIL master_wr_count: got %0d, required 1", obs_data.size());
        end
        for (int i = 0; i < obs_data.size(); i++) begin
            exp_w = 16'h0;
            if (exp_q.size() > 0) exp_w = exp_q.pop_front();
            checks++;
            if (obs_addr[i] !== 4'(i) || obs_data[i] !== exp_w || exp_w !== 16'hA5C3) begin
                failures++;
                $display("FAIL master_write: addr=%0d data=%h, required addr=%0d data=a5c3", obs_addr[i], obs_data[i], i);
            end
        end
        checks++;
        if (crc_hi != 8 || crc_bad != 0 || data_bad != 0 || stray != 0) begin
            failures++;
            $display("FAIL master_timing: crc_hi=%0d crc_bad=%0d data_bad=%0d stray=%0d, required 8/0/0/0",
                     crc_hi, crc_bad, data_bad, stray);
        end
        for (int e = 0; e < 5; e++) begin
            tick();
            idle_inputs();
            if (e == 2) bus.end_det = 1'b1;
            settle();
`ifdef MVB_RX_CRC_CAPTURE_EN
            if (e == 0) begin
                checks++;
                if (bus.crc_valid !== 1'b1 || bus.crc_byte !== 8'h3B) begin
                    failures++; $display("FAIL crc_capture: valid=%b byte=%h, required 1/3b", bus.crc_valid, bus.crc_byte);
                end
            end
            if (e == 1) begin
                checks++;
                if (bus.crc_valid !== 1'b0 || bus.crc_byte !== 8'h3B) begin
                    failures++; $display("FAIL crc_hold: valid=%b byte=%h, required 0/3b", bus.crc_valid, bus.crc_byte);
                end
            end
`endif
            if (e < 3) begin
                checks++;
                if (bus.frame_done !== 1'b0 || bus.busy !== 1'b1 || bus.crc_window !== 1'b0 || bus.des_wait !== 1'b1) begin
                    failures++;
                    $display("FAIL master_end_wait%0d: done=%b busy=%b crc=%b des_wait=%b, required 0/1/0/1",
                             e, bus.frame_done, bus.busy, bus.crc_window, bus.des_wait);
                end
            end else if (e == 3) begin
                checks++;
                if (bus.frame_done !== 1'b1 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL master_done: done=%b err=%b busy=%b, required 1/0/0", bus.frame_done, bus.frame_err, bus.busy);
                end
            end else begin
                checks++;
                if (bus.frame_done !== 1'b0) begin
                    failures++; $display("FAIL master_done_pulse: done=%b, required 0", bus.frame_done);
                end
            end
        end
    endtask

    task automatic test_slave_frames();
        logic [15:0] exp_w;
        int          n;
        for (int t = 0; t < 2; t++) begin
            n = (t == 0) ? 8 : 16;
            word_base = (t == 0) ? 16'h1000 : 16'hF00F;
            crc_pat   = 8'hC6;
            start_frame(1'b1, (t == 0) ? 3'd3 : 3'd4);
            drive_frame(n, 4);
            checks++;
            if (obs_data.size() != n) begin
                failures++; $display("FAIL slave%0d_wr_count: got %0d, required %0d", n, obs_data.size(), n);
            end
            for (int i = 0; i < obs_data.size(); i++) begin
                exp_w = 16'h0;
                if (exp_q.size() > 0) exp_w = exp_q.pop_front();
                checks++;
                if (obs_addr[i] !== 4'(i) || obs_data[i] !== exp_w) begin
                    failures++;
                    $display("FAIL slave%0d_write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                             n, i, obs_addr[i], obs_data[i], i, exp_w);
                end
            end
            checks++;
            if (crc_hi != 2 * n || crc_bad != 0 || data_bad != 0 || stray != 0) begin
                failures++;
                $display("FAIL slave%0d_timing: crc_hi=%0d crc_bad=%0d data_bad=%0d stray=%0d, required %0d/0/0/0",
                         n, crc_hi, crc_bad, data_bad, stray, 2 * n);
            end
            tick();
            idle_inputs();
            bus.end_det = 1'b1;
            settle();
            checks++;
            if (bus.busy !== 1'b1 || bus.frame_done !== 1'b0) begin
                failures++; $display("FAIL slave%0d_end_wait: busy=%b done=%b, required 1/0", n, bus.busy, bus.frame_done);
            end
            tick();
            idle_inputs();
            settle();
            checks++;
            if (bus.frame_done !== 1'b1 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL slave%0d_done: done=%b err=%b busy=%b, required 1/0/0", n, bus.frame_done, bus.frame_err, bus.busy);
            end
        end
    endtask

    task automatic test_end_timeout();
        int bad;
        bad = 0;
        word_base = 16'h2222;
        start_frame(1'b1, 3'd1);
        drive_frame(2, 2);
        checks++;
        if (obs_data.size() != 2 || crc_hi != 8) begin
            failures++; $display("FAIL timeout_frame: writes=%0d crc_hi=%0d, required 2/8", obs_data.size(), crc_hi);
        end
        for (int e = 0; e <= 12; e++) begin
            tick();
            idle_inputs();
            settle();
            if (e < 12) begin
                if (bus.frame_err !== 1'b0 || bus.busy !== 1'b1) bad++;
            end else begin
                checks++;
                if (bus.frame_err !== 1'b1 || bus.err_code !== 2'b01 || bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_err: err=%b code=%b done=%b busy=%b, required 1/01/0/0",
                             bus.frame_err, bus.err_code, bus.frame_done, bus.busy);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL timeout_early: %0d cycles with early error or not busy, required 0", bad);
        end
    endtask

    task automatic test_bad_size();
        int bad;
        bad = 0;
        tick();
        idle_inputs();
        bus.start_det      = 1'b1;
        bus.frame_is_slave = 1'b1;
        bus.size_code      = 3'd5;
        tick();
        idle_inputs();
        settle();
        checks++;
        if (bus.frame_err !== 1'b1 || bus.err_code !== 2'b00 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_size_err: err=%b code=%b busy=%b, required 1/00/0", bus.frame_err, bus.err_code, bus.busy);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            idle_inputs();
            settle();
            if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.frame_err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL bad_size_quiet: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_sync_lost();
        start_frame(1'b1, 3'd2);
        for (int c = 0; c < 34; c++) begin
            tick();
            idle_inputs();
            bus.word_valid = (c == 16);
            bus.word_in    = (c == 16) ? 16'hBEEF : 16'h0;
            settle();
            if (c < 33) begin
                record_write();
            end else begin
                checks++;
                if (bus.frame_err !== 1'b1 || bus.err_code !== 2'b10 || bus.busy !== 1'b0 || bus.des_wait !== 1'b1) begin
                    failures++;
                    $display("FAIL sync_lost_err: err=%b code=%b busy=%b des_wait=%b, required 1/10/0/1",
                             bus.frame_err, bus.err_code, bus.busy, bus.des_wait);
                end
            end
        end
        checks++;
        if (obs_data.size() != 1 || stray != 0) begin
            failures++; $display("FAIL sync_lost_writes: writes=%0d stray=%0d, required 1/0", obs_data.size(), stray);
        end else begin
            checks++;
            if (obs_addr[0] !== 4'd0 || obs_data[0] !== 16'hBEEF) begin
                failures++; $display("FAIL sync_lost_word0: addr=%0d data=%h, required 0/beef", obs_addr[0], obs_data[0]);
            end
        end
    endtask

    task automatic test_restart();
        start_frame(1'b0, 3'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            idle_inputs();
        end
        tick();
        bus.start_det = 1'b1;
        settle();
        checks++;
        if (bus.busy !== 1'b1 || bus.frame_err !== 1'b0) begin
            failures++; $display("FAIL restart_pre: busy=%b err=%b, required 1/0", bus.busy, bus.frame_err);
        end
        tick();
        idle_inputs();
        settle();
        checks++;
        if (bus.frame_err !== 1'b1 || bus.err_code !== 2'b11 || bus.busy !== 1'b0 || bus.des_wait !== 1'b1) begin
            failures++;
            $display("FAIL restart_err: err=%b code=%b busy=%b des_wait=%b, required 1/11/0/1",
                     bus.frame_err, bus.err_code, bus.busy, bus.des_wait);
        end
        tick();
        settle();
        checks++;
        if (bus.busy !== 1'b0 || bus.frame_err !== 1'b0 || bus.err_code !== 2'b11) begin
            failures++;
            $display("FAIL restart_no_restart: busy=%b err=%b code=%b, required 0/0/11", bus.busy, bus.frame_err, bus.err_code);
        end
    endtask

    task automatic test_reset_mid_crc();
        start_frame(1'b0, 3'd0);
        for (int c = 0; c < 19; c++) begin
            tick();
            idle_inputs();
            bus.word_valid = (c == 16);
            bus.word_in    = (c == 16) ? 16'h1234 : 16'h0;
        end
        settle();
        checks++;
        if (bus.crc_window !== 1'b1 || bus.des_wait !== 1'b1) begin
            failures++; $display("FAIL rst_mid_crc_pre: crc=%b des_wait=%b, required 1/1", bus.crc_window, bus.des_wait);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.des_wait !== 1'b1 || bus.crc_window !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_crc_state: des_wait=%b crc=%b busy=%b, required 1/0/0", bus.des_wait, bus.crc_window, bus.busy);
        end
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_err, bus.err_code} !== 25'h0) begin
            failures++;
            $display("FAIL rst_mid_crc_outputs: wr_en=%b addr=%h data=%h done=%b err=%b code=%b, required all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_err, bus.err_code);
        end
        settle();
        rst = 1'b0;
        tick();
        settle();
        checks++;
        if (bus.busy !== 1'b0 || bus.des_wait !== 1'b1) begin
            failures++; $display("FAIL rst_mid_crc_after: busy=%b des_wait=%b, required 0/1", bus.busy, bus.des_wait);
        end
    endtask

    initial begin
        test_reset();
        test_master_frame();
        test_slave_frames();
        test_end_timeout();
        test_bad_size();
        test_sync_lost();
        test_restart();
        test_reset_mid_crc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
